// File: rtl/seg7_scan_pkg.sv
// Shared definitions for the seven-segment scan driver.
// Segment patterns are {g,f,e,d,c,b,a}, active-high. Polarity is applied only at the output register.
package seg7_scan_pkg;

  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_A   = 7'h77;
  localparam logic [6:0] SEG_B   = 7'h7C;
  localparam logic [6:0] SEG_C   = 7'h39;
  localparam logic [6:0] SEG_D   = 7'h5E;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_F   = 7'h71;
  localparam logic [6:0] SEG_OFF = 7'h00;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to seven-segment decoder (active-high segments).
module hex_to_seg7
  import seg7_scan_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed seven-segment driver; the scan clock is sampled as data and edge-detected.
// Each frame is taken from a snapshot loaded on index wrap, so input changes never tear a frame.
module seg7_scan
  import seg7_scan_pkg::*;
#(
  parameter  int DIGITS     = 8,
  parameter  bit ACTIVE_LOW = 1'b1,
  localparam int IDXW       = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scan_clk,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  blank_lz,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [IDXW-1:0]       digit_idx
);

  localparam logic [IDXW-1:0] LAST = IDXW'(DIGITS - 1);

  logic                s1, s2, s3;
  logic                tick;
  logic [IDXW-1:0]     idx, idx_nxt;
  logic                frame_valid;
  logic [4*DIGITS-1:0] snap_data;
  logic [DIGITS-1:0]   snap_dp;
  logic [DIGITS-1:0]   lz_mask;
  logic [3:0]          nib;
  logic [6:0]          seg_raw;
  logic                blank;

  assign tick    = s2 & ~s3;
  assign idx_nxt = (idx == LAST) ? '0 : idx + IDXW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      idx         <= '0;
      frame_valid <= 1'b0;
      snap_data   <= '0;
      snap_dp     <= '0;
    end else begin
      s1 <= scan_clk;
      s2 <= s1;
      s3 <= s2;
      if (tick) begin
        // The first tick after reset only loads the snapshot; idx stays at 0.
        if (frame_valid)
          idx <= idx_nxt;
        if (!frame_valid || idx_nxt == '0) begin
          snap_data   <= data;
          snap_dp     <= dp_mask;
          frame_valid <= 1'b1;
        end
      end
    end
  end

  // lz_mask[i]: snapshot nibbles DIGITS-1..i are all zero. Digit 0 is never a candidate.
  always_comb begin
    logic zero_above;
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (snap_data[4*i +: 4] == 4'h0);
      lz_mask[i] = zero_above;
    end
  end

  assign nib   = snap_data[4*int'(idx) +: 4];
  assign blank = blank_lz & lz_mask[idx];

  hex_to_seg7 u_dec (
    .hex (nib),
    .seg (seg_raw)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || !frame_valid) begin
      an        <= {DIGITS{ACTIVE_LOW}};
      seg       <= {7{ACTIVE_LOW}};
      dp        <= ACTIVE_LOW;
      digit_idx <= '0;
    end else begin
      an        <= (DIGITS'(1) << idx) ^ {DIGITS{ACTIVE_LOW}};
      seg       <= (blank ? SEG_OFF : seg_raw) ^ {7{ACTIVE_LOW}};
      dp        <= snap_dp[idx] ^ ACTIVE_LOW;
      digit_idx <= idx;
    end
  end

endmodule
